// File: rtl/trace_pipe_pkg.sv
// Shared trace-entry type and stage indices for the instruction-trace pipeline.
// TRACE_PIPE_CYCLE_EN adds a commit-cycle stamp field to each trace entry.
package trace_pipe_pkg;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_X = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  // Default-width entry; the pipe builds its own entry type from its parameters.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] data;
`ifdef TRACE_PIPE_CYCLE_EN
    logic [31:0] cycle;
`endif
  } trace_entry_t;

endpackage

// File: rtl/trace_pipe_if.sv
// Bundle of the F-stage trace inputs, stage controls and the commit stream.
// out_val/out_rdy: an entry transfers on every clock edge where both are high.
interface trace_pipe_if #(
  parameter int NSTAGES = 5,
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int DATA_W  = 32
);
  logic                f_val;
  logic [ADDR_W-1:0]   f_addr;
  logic [INST_W-1:0]   f_inst;
  logic [NSTAGES-2:0]  stall;
  logic [NSTAGES-2:0]  squash;
  logic [DATA_W-1:0]   w_data;
  logic                out_val;
  logic                out_rdy;
  logic [ADDR_W-1:0]   out_addr;
  logic [INST_W-1:0]   out_inst;
  logic [DATA_W-1:0]   out_data;
  logic                overflow;
  logic [31:0]         commit_cnt;
`ifdef TRACE_PIPE_CYCLE_EN
  logic [31:0]         out_cycle;
`endif

  modport master (
    output f_val, f_addr, f_inst, stall, squash, w_data, out_rdy,
    input  out_val, out_addr, out_inst, out_data, overflow, commit_cnt
`ifdef TRACE_PIPE_CYCLE_EN
    , input out_cycle
`endif
  );

  modport slave (
    input  f_val, f_addr, f_inst, stall, squash, w_data, out_rdy,
    output out_val, out_addr, out_inst, out_data, overflow, commit_cnt
`ifdef TRACE_PIPE_CYCLE_EN
    , output out_cycle
`endif
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous commit FIFO with val/rdy output and a sticky drop flag.
// A push into a full FIFO is accepted only if the head is popped in the same cycle.
module trace_fifo
  import trace_pipe_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = trace_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t push_data_i,
  output logic   push_acc_o,
  output logic   overflow_o,
  output logic   val_o,
  input  logic   rdy_i,
  output entry_t data_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          full, pop;

  assign val_o      = (cnt_q != '0);
  assign full       = (cnt_q == FULL_CNT);
  assign pop        = val_o & rdy_i;
  assign push_acc_o = push_i & (~full | pop);
  assign overflow_o = ovf_q;
  // Idle output reads as zero rather than exposing a stale slot.
  assign data_o     = val_o ? mem_q[rd_q] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_acc_o) wr_q <= wr_q + AW'(1);
      if (pop)        rd_q <= rd_q + AW'(1);
      if (push_acc_o && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push_acc_o) cnt_q <= cnt_q - (AW+1)'(1);
      if (push_i && !push_acc_o)   ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc_o) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/trace_pipe.sv
// Instruction-trace pipeline: tracks F..W with stall/squash, commits into trace_fifo.
// Define TRACE_PIPE_CYCLE_EN to stamp each commit with a free-running cycle count.
module trace_pipe
  import trace_pipe_pkg::*;
#(
  parameter int NSTAGES    = 5,
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  trace_pipe_if.slave bus
);
  localparam int L = NSTAGES - 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] data;
`ifdef TRACE_PIPE_CYCLE_EN
    logic [31:0]       cycle;
`endif
  } entry_t;

  logic [L:1]        v_q;
  logic [ADDR_W-1:0] addr_q [1:L];
  logic [INST_W-1:0] inst_q [1:L];

  logic [L:0]        h, sv, sq;
  logic [ADDR_W-1:0] sa [0:L];
  logic [INST_W-1:0] si [0:L];

  logic   commit, push_acc, fifo_ovf, fifo_val;
  entry_t push_e, out_e;
  logic [31:0] commit_cnt_q;

  // Stage view: index STG_F is the live fetch input, later indices are registers.
  // h[i] is high when any stall at stage i or later freezes stage i.
  always_comb begin
    h  = '0;
    sv = '0;
    sq = '0;
    sv[STG_F] = bus.f_val;
    sa[STG_F] = bus.f_addr;
    si[STG_F] = bus.f_inst;
    for (int i = 1; i <= L; i++) begin
      h[i]  = |(bus.stall >> (i - 1));
      sv[i] = v_q[i];
      sq[i] = bus.squash[i-1];
      sa[i] = addr_q[i];
      si[i] = inst_q[i];
    end
    h[STG_F] = h[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int i = 1; i <= L; i++) begin
        addr_q[i] <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i <= L; i++) begin
        if (!h[i]) begin
          // A held or squashed predecessor hands over a bubble.
          v_q[i]    <= sv[i-1] & ~h[i-1] & ~sq[i-1];
          addr_q[i] <= sa[i-1];
          inst_q[i] <= si[i-1];
        end else if (bus.squash[i-1]) begin
          v_q[i] <= 1'b0;
        end
      end
    end
  end

  assign commit = sv[L] & ~sq[L] & ~bus.stall[L-1];

`ifdef TRACE_PIPE_CYCLE_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_q <= '0;
    else      cyc_q <= cyc_q + 32'd1;
  end
  assign bus.out_cycle = out_e.cycle;
`endif

  always_comb begin
    push_e      = '0;
    push_e.addr = sa[L];
    push_e.inst = si[L];
    push_e.data = bus.w_data;
`ifdef TRACE_PIPE_CYCLE_EN
    push_e.cycle = cyc_q;
`endif
  end

  trace_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (commit),
    .push_data_i (push_e),
    .push_acc_o  (push_acc),
    .overflow_o  (fifo_ovf),
    .val_o       (fifo_val),
    .rdy_i       (bus.out_rdy),
    .data_o      (out_e)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          commit_cnt_q <= '0;
    else if (push_acc) commit_cnt_q <= commit_cnt_q + 32'd1;
  end

  assign bus.out_val    = fifo_val;
  assign bus.out_addr   = out_e.addr;
  assign bus.out_inst   = out_e.inst;
  assign bus.out_data   = out_e.data;
  assign bus.overflow   = fifo_ovf;
  assign bus.commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_trace_pipe.sv
// Directed bench for trace_pipe: straight flow, stall, squash, overflow,
// full push+pop and asynchronous mid-stream reset, with a commit scoreboard.
module tb_trace_pipe;
  import trace_pipe_pkg::*;

  localparam int NS = 5;
  localparam int FD = 4;
  localparam logic [3:0] NONE    = 4'b0000;
  localparam logic [3:0] STALL_X = 4'(1 << (STG_X - 1));
  localparam logic [3:0] SQ_D    = 4'(1 << (STG_D - 1));

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  trace_pipe_if #(.NSTAGES(NS), .ADDR_W(32), .INST_W(32), .DATA_W(32)) bus ();

  trace_pipe #(
    .NSTAGES(NS), .ADDR_W(32), .INST_W(32), .DATA_W(32), .FIFO_DEPTH(FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [95:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], 16'h0093};
  endfunction

  task automatic exp_push(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, inst_of(a), d});
  endtask

  task automatic check_out(input string tag);
    logic [95:0] e;
    e = '0;
    chk({tag, "_pending"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_val"},  32'(bus.out_val), 32'd1);
    chk({tag, "_addr"}, bus.out_addr, e[95:64]);
    chk({tag, "_inst"}, bus.out_inst, e[63:32]);
    chk({tag, "_data"}, bus.out_data, e[31:0]);
  endtask

  task automatic step(input logic fv, input logic [31:0] fa, input logic [3:0] st,
                      input logic [3:0] sq, input logic [31:0] wd);
    bus.f_val  = fv;
    bus.f_addr = fa;
    bus.f_inst = inst_of(fa);
    bus.stall  = st;
    bus.squash = sq;
    bus.w_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.f_val = 1'b0; bus.f_addr = '0; bus.f_inst = '0;
    bus.stall = '0;   bus.squash = '0; bus.w_data = '0;
    bus.out_rdy = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_val",  32'(bus.out_val), 32'd0);
    chk("rst_addr", bus.out_addr, 32'h0);
    chk("rst_data", bus.out_data, 32'h0);
    chk("rst_ovf",  32'(bus.overflow), 32'd0);
    chk("rst_cnt",  bus.commit_cnt, 32'd0);

    // 1: straight flow, first out_val five edges after F
    bus.out_rdy = 1'b1;
    exp_push(32'h200, 32'h11); exp_push(32'h204, 32'h22); exp_push(32'h208, 32'h33);
    step(1, 32'h200, NONE, NONE, 0);
    step(1, 32'h204, NONE, NONE, 0);
    step(1, 32'h208, NONE, NONE, 0);
    step(0, 0, NONE, NONE, 0);
    chk("t1_early", 32'(bus.out_val), 32'd0);
    step(0, 0, NONE, NONE, 32'h11); check_out("t1_e0");
    step(0, 0, NONE, NONE, 32'h22); check_out("t1_e1");
    step(0, 0, NONE, NONE, 32'h33); check_out("t1_e2");
    step(0, 0, NONE, NONE, 0);
    chk("t1_drained", 32'(bus.out_val), 32'd0);
    chk("t1_cnt", bus.commit_cnt, 32'd3);

    // 2: X stalled two cycles with 0x200 in X; F keeps presenting 0x208
    do_reset();
    bus.out_rdy = 1'b1;
    exp_push(32'h200, 32'h11); exp_push(32'h204, 32'h22); exp_push(32'h208, 32'h33);
    step(1, 32'h200, NONE, NONE, 0);
    step(1, 32'h204, NONE, NONE, 0);
    step(1, 32'h208, STALL_X, NONE, 0);
    step(1, 32'h208, STALL_X, NONE, 0);
    step(1, 32'h208, NONE, NONE, 0);
    step(0, 0, NONE, NONE, 0);
    chk("t2_late", 32'(bus.out_val), 32'd0);
    step(0, 0, NONE, NONE, 32'h11); check_out("t2_e0");
    step(0, 0, NONE, NONE, 32'h22); check_out("t2_e1");
    step(0, 0, NONE, NONE, 32'h33); check_out("t2_e2");
    step(0, 0, NONE, NONE, 0);
    chk("t2_drained", 32'(bus.out_val), 32'd0);
    chk("t2_cnt", bus.commit_cnt, 32'd3);

    // 3: squash D while it holds 0x204
    do_reset();
    bus.out_rdy = 1'b1;
    exp_push(32'h200, 32'h11); exp_push(32'h208, 32'h33);
    step(1, 32'h200, NONE, NONE, 0);
    step(1, 32'h204, NONE, NONE, 0);
    step(1, 32'h208, NONE, SQ_D, 0);
    step(0, 0, NONE, NONE, 0);
    step(0, 0, NONE, NONE, 32'h11); check_out("t3_e0");
    step(0, 0, NONE, NONE, 32'h22);
    chk("t3_hole", 32'(bus.out_val), 32'd0);
    step(0, 0, NONE, NONE, 32'h33); check_out("t3_e1");
    step(0, 0, NONE, NONE, 0);
    chk("t3_drained", 32'(bus.out_val), 32'd0);
    chk("t3_cnt", bus.commit_cnt, 32'd2);

    // 4: five commits into a four-entry FIFO with the consumer stalled
    do_reset();
    for (int i = 0; i < 4; i++) exp_push(32'h300 + 32'(4 * i), 32'hA1 + 32'(i));
    step(1, 32'h300, NONE, NONE, 0);
    step(1, 32'h304, NONE, NONE, 0);
    step(1, 32'h308, NONE, NONE, 0);
    step(1, 32'h30c, NONE, NONE, 0);
    step(1, 32'h310, NONE, NONE, 32'hA1);
    step(0, 0, NONE, NONE, 32'hA2);
    step(0, 0, NONE, NONE, 32'hA3);
    step(0, 0, NONE, NONE, 32'hA4);
    chk("t4_full_ovf", 32'(bus.overflow), 32'd0);
    chk("t4_full_cnt", bus.commit_cnt, 32'd4);
    step(0, 0, NONE, NONE, 32'hA5);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    chk("t4_cnt", bus.commit_cnt, 32'd4);
    check_out("t4_e0");
    bus.out_rdy = 1'b1;
    step(0, 0, NONE, NONE, 0); check_out("t4_e1");
    step(0, 0, NONE, NONE, 0); check_out("t4_e2");
    step(0, 0, NONE, NONE, 0); check_out("t4_e3");
    step(0, 0, NONE, NONE, 0);
    chk("t4_drained", 32'(bus.out_val), 32'd0);
    chk("t4_sticky", 32'(bus.overflow), 32'd1);

    // 6: asynchronous reset between edges with entries buffered and in flight
    bus.out_rdy = 1'b0;
    step(1, 32'h400, NONE, NONE, 0);
    step(1, 32'h404, NONE, NONE, 0);
    step(1, 32'h408, NONE, NONE, 0);
    step(1, 32'h40c, NONE, NONE, 0);
    step(0, 0, NONE, NONE, 32'hB1);
    chk("t6_pre_val", 32'(bus.out_val), 32'd1);
    chk("t6_pre_cnt", bus.commit_cnt, 32'd5);
    #3 rst = 1'b0;
    #1;
    chk("t6_rst_val",  32'(bus.out_val), 32'd0);
    chk("t6_rst_addr", bus.out_addr, 32'h0);
    chk("t6_rst_ovf",  32'(bus.overflow), 32'd0);
    chk("t6_rst_cnt",  bus.commit_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, NONE, NONE, 32'hB2);
      chk("t6_stale_val", 32'(bus.out_val), 32'd0);
    end
    chk("t6_stale_cnt", bus.commit_cnt, 32'd0);

    // 5: FIFO full, consumer pops while the fifth entry commits
    do_reset();
    for (int i = 0; i < 5; i++) exp_push(32'h300 + 32'(4 * i), 32'hA1 + 32'(i));
    step(1, 32'h300, NONE, NONE, 0);
    step(1, 32'h304, NONE, NONE, 0);
    step(1, 32'h308, NONE, NONE, 0);
    step(1, 32'h30c, NONE, NONE, 0);
    step(1, 32'h310, NONE, NONE, 32'hA1);
    step(0, 0, NONE, NONE, 32'hA2);
    step(0, 0, NONE, NONE, 32'hA3);
    step(0, 0, NONE, NONE, 32'hA4);
    chk("t5_full_cnt", bus.commit_cnt, 32'd4);
    check_out("t5_e0");
    bus.out_rdy = 1'b1;
    step(0, 0, NONE, NONE, 32'hA5);
    chk("t5_ovf", 32'(bus.overflow), 32'd0);
    chk("t5_cnt", bus.commit_cnt, 32'd5);
    check_out("t5_e1");
    step(0, 0, NONE, NONE, 0); check_out("t5_e2");
    step(0, 0, NONE, NONE, 0); check_out("t5_e3");
    step(0, 0, NONE, NONE, 0); check_out("t5_e4");
    step(0, 0, NONE, NONE, 0);
    chk("t5_drained", 32'(bus.out_val), 32'd0);
    chk("t5_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
